// File: rtl/load_issue_arb.sv
// load_issue_arb: shares the operand-load issue port among NUM_REQ issue queues.
// Picks one ready uop per cycle, oldest-first by sequence number, and
// registers it into a one-entry output slot. A per-requester wait counter
// forces a grant to a queue that has been passed over too long. Branch
// invalidation kills younger requests and the held slot.
module load_issue_arb #(
   parameter int NUM_REQ    = 4,
   parameter int UOP_W      = 101,
   parameter int SQN_W      = 7,
   parameter int STARVE_LIM = 7
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           IN_reqValid,
   input  logic [NUM_REQ*SQN_W-1:0]     IN_reqSqN,
   input  logic [NUM_REQ*UOP_W-1:0]     IN_reqUop,
   output logic [NUM_REQ-1:0]           OUT_reqAck,
   input  logic                         IN_stall,
   input  logic                         IN_invalidate,
   input  logic [SQN_W-1:0]             IN_invalidateSqN,
   output logic                         OUT_uopValid,
   output logic [UOP_W-1:0]             OUT_uop,
   output logic [SQN_W-1:0]             OUT_sqN,
   output logic [$clog2(NUM_REQ)-1:0]   OUT_grantIdx
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam logic [3:0] LIM = 4'(STARVE_LIM);

   // a is older than b when (a - b) is negative in SQN_W-bit arithmetic,
   // which keeps the ordering correct across sequence-number wrap-around
   function automatic logic f_older(input logic [SQN_W-1:0] a, input logic [SQN_W-1:0] b);
      logic [SQN_W-1:0] d;
      d = a - b;
      return d[SQN_W-1];
   endfunction

   // a uop is killed when it is strictly younger than the flush point;
   // equal sqN survives
   function automatic logic f_killed(input logic inv, input logic [SQN_W-1:0] sqn,
                                     input logic [SQN_W-1:0] inv_sqn);
      logic [SQN_W-1:0] d;
      d = sqn - inv_sqn;
      return inv && !d[SQN_W-1] && (d != '0);
   endfunction

   logic [SQN_W-1:0] w_req_sqn [NUM_REQ];
   logic [UOP_W-1:0] w_req_uop [NUM_REQ];
   logic [NUM_REQ-1:0] w_eligible;
   logic [NUM_REQ-1:0] w_starved;
   logic [3:0]       r_wait_cnt [NUM_REQ];

   logic             r_valid;
   logic [UOP_W-1:0] r_uop;
   logic [SQN_W-1:0] r_sqn;
   logic [IDX_W-1:0] r_idx;

   logic             w_accept;
   logic             w_slot_killed;
   logic             w_starve_found;
   logic [IDX_W-1:0] w_starve_idx;
   logic             w_age_found;
   logic [IDX_W-1:0] w_age_idx;
   logic [SQN_W-1:0] w_age_sqn;
   logic             w_win_valid;
   logic [IDX_W-1:0] w_win_idx;
   logic [NUM_REQ-1:0] w_ack;

   // unpack per-requester fields and qualify each request
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign w_req_sqn[gi]  = IN_reqSqN[gi*SQN_W +: SQN_W];
      assign w_req_uop[gi]  = IN_reqUop[gi*UOP_W +: UOP_W];
      assign w_eligible[gi] = IN_reqValid[gi] &&
                              !f_killed(IN_invalidate, w_req_sqn[gi], IN_invalidateSqN);
      assign w_starved[gi]  = (r_wait_cnt[gi] == LIM);
   end

   // the slot can take a new uop when empty or being drained this cycle
   assign w_accept      = !r_valid || !IN_stall;
   assign w_slot_killed = r_valid && f_killed(IN_invalidate, r_sqn, IN_invalidateSqN);

   // winner selection: lowest starved index first, otherwise oldest sqN
   // with ties going to the lowest index
   always_comb begin
      w_starve_found = 1'b0;
      w_starve_idx   = '0;
      w_age_found    = 1'b0;
      w_age_idx      = '0;
      w_age_sqn      = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (w_eligible[i] && w_starved[i]) begin
            w_starve_found = 1'b1;
            w_starve_idx   = IDX_W'(i);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_eligible[i] && (!w_age_found || f_older(w_req_sqn[i], w_age_sqn))) begin
            w_age_found = 1'b1;
            w_age_idx   = IDX_W'(i);
            w_age_sqn   = w_req_sqn[i];
         end
      end
      w_win_valid = w_starve_found || w_age_found;
      w_win_idx   = w_starve_found ? w_starve_idx : w_age_idx;
   end

   // one-hot acknowledge for the winner, suppressed while reset is held
   always_comb begin
      w_ack = '0;
      if (rst && w_accept && w_win_valid) begin
         w_ack[w_win_idx] = 1'b1;
      end
   end

   assign OUT_reqAck = w_ack;

   // per-requester wait counters; a killed but still valid request keeps counting
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REQ; i++) r_wait_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!IN_reqValid[i] || w_ack[i]) begin
               r_wait_cnt[i] <= '0;
            end else if (r_wait_cnt[i] != LIM) begin
               r_wait_cnt[i] <= r_wait_cnt[i] + 4'd1;
            end
         end
      end
   end

   // output slot: load winner, drain, drop when killed under stall, or hold
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid <= 1'b0;
         r_uop   <= '0;
         r_sqn   <= '0;
         r_idx   <= '0;
      end else if (w_accept) begin
         r_valid <= w_win_valid;
         if (w_win_valid) begin
            r_uop <= w_req_uop[w_win_idx];
            r_sqn <= w_req_sqn[w_win_idx];
            r_idx <= w_win_idx;
         end
      end else if (w_slot_killed) begin
         r_valid <= 1'b0;
      end
   end

   assign OUT_uopValid = r_valid;
   assign OUT_uop      = r_uop;
   assign OUT_sqN      = r_sqn;
   assign OUT_grantIdx = r_idx;

endmodule

// File: doc/load_issue_arb.md
# load_issue_arb

Shares the single issue port of the operand-load stage among `NUM_REQ` issue queues. Each cycle it picks one ready micro-op, oldest-first by sequence number, and registers it into a one-entry output slot that feeds the load stage's `IN_uopValid`/`IN_uop`. A per-requester wait counter forces a grant to any queue that has been passed over for too long. Branch-mispredict invalidation kills younger requests and the held slot.

## Interface
- `NUM_REQ`, 4, number of requesting issue queues (power of two, 2..8)
- `UOP_W`, 101, payload width; passed through unmodified
- `SQN_W`, 7, sequence-number width
- `STARVE_LIM`, 7, wait cycles after which a requester is starved (1..15)

- `clk`  in  1  clock; all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `IN_reqValid`  in  NUM_REQ  requester i presents a uop
- `IN_reqSqN`  in  NUM_REQ*SQN_W  sqN of requester i, slice i*SQN_W+:SQN_W
- `IN_reqUop`  in  NUM_REQ*UOP_W  payload of requester i
- `OUT_reqAck`  out  NUM_REQ  combinational one-hot; requester i's uop taken this cycle
- `IN_stall`  in  1  load stage cannot take the slot this cycle
- `IN_invalidate`  in  1  flush request
- `IN_invalidateSqN`  in  SQN_W  uops strictly younger than this are killed
- `OUT_uopValid`  out  1  slot holds a uop
- `OUT_uop`  out  UOP_W  slot payload
- `OUT_sqN`  out  SQN_W  slot sqN
- `OUT_grantIdx`  out  log2(NUM_REQ)  requester that filled the slot

## Operation
- Age compare: a is older than b iff `$signed(a - b) < 0`, evaluated in SQN_W bits, so wrap-around is handled.
- Killed: `IN_invalidate && $signed(sqN - IN_invalidateSqN) > 0`. Equal sqN survives.
- Eligible[i] = `IN_reqValid[i]` && requester i not killed.
- `accept` = `!OUT_uopValid || !IN_stall`.
- Winner selection, applied only when `accept`:
  - If any eligible requester has `waitCnt == STARVE_LIM`, the lowest such index wins.
  - Otherwise the oldest eligible sqN wins. On equal sqN, the lowest index wins.
- `OUT_reqAck` is one-hot for the winner. It is all-zero if there is no winner or `accept` is 0.
- Slot update, in priority order:
  1. `accept` with a winner: load its uop, sqN and index; set valid.
  2. `accept` with no winner: clear valid. Payload is don't-care.
  3. No `accept` (slot held under stall) and the slot is killed: clear valid.
  4. Otherwise hold.
- `waitCnt[i]` (4 bits):
  - Cleared when `!IN_reqValid[i]` or when i is acked.
  - Otherwise increments, saturating at STARVE_LIM.
  - A killed but still valid request keeps counting.
- Reset:
  - `OUT_uopValid` = 0, `OUT_uop` = 0, `OUT_sqN` = 0, `OUT_grantIdx` = 0, all `waitCnt` = 0.
  - `OUT_reqAck` = 0 while `rst` is low.

## Timing
- Grant: same cycle as request, combinationally from inputs and state.
- Latency: request acked in cycle N appears on `OUT_uop` at cycle N+1.
- Throughput: one uop per cycle while `IN_stall` = 0.
- Stall: a held slot is stable until the first cycle with `IN_stall` = 0. In that cycle it is consumed and replaced (back-to-back, no bubble).
- Invalidate and accept in the same cycle: killed requesters are excluded and the next-oldest eligible wins. A killed held slot is dropped even under stall.
- No combinational path from `IN_stall` to `OUT_uopValid`. The path from `IN_stall` to `OUT_reqAck` exists and is permitted.
- Asynchronous reset assertion mid-transfer drops the slot immediately. The first grant is possible in the first clock after `rst` deasserts.

## Test plan
- Age order:
  - Stimulus: valid=4'b1111, sqN={3,9,5,7} (req0..3), no stall.
  - Response: ack=0001, next cycle sqN=3, grantIdx=0.
  - Then, with req0 dropped: ack=0100, slot sqN=5.
- Wrap-around:
  - Stimulus: req0 sqN=126, req1 sqN=2.
  - Response: req0 wins (126 is older than 2). Swapping the values makes req1 win.
- Stall hold:
  - Stimulus: slot holds sqN=10, `IN_stall`=1 for 3 cycles, req1 valid.
  - Response: ack=0 and slot unchanged for those 3 cycles. In the cycle stall drops, ack=0010 and req1 appears next cycle.
- Invalidate:
  - Stimulus: slot holds sqN=20 under stall; `IN_invalidate`=1, invSqN=15.
  - Response: `OUT_uopValid`=0 next cycle. With invSqN=20 instead, the slot is kept.
  - Stimulus: same cycle, req sqN={18,12}.
  - Response: req1 is granted.
- Starvation:
  - Stimulus: req3 valid with sqN=50; req0 continuously valid with sqN=1 (re-presented each cycle).
  - Response: req3 is acked in the 8th cycle (STARVE_LIM=7), then req0 resumes. waitCnt[3] returns to 0.
- Reset mid-op:
  - Stimulus: `rst` low asynchronously while slot valid.
  - Response: `OUT_uopValid`=0 with no clock edge; all counters 0.
